// File: rtl/updown_dir_ctrl_if.sv
// Signal bundle between the direction controller and its environment:
// mode/limit/button/count inputs and the direction, reversal and error outputs.
interface updown_dir_ctrl_if;
  logic [1:0] mode;
  logic       btn_dir;
  logic [3:0] count;
  logic [3:0] lo_lim;
  logic [3:0] hi_lim;
  logic       upordown;
  logic       rev_pulse;
  logic [7:0] rev_cnt;
  logic       lim_err;

  modport master (
    output mode, btn_dir, count, lo_lim, hi_lim,
    input  upordown, rev_pulse, rev_cnt, lim_err
  );

  modport slave (
    input  mode, btn_dir, count, lo_lim, hi_lim,
    output upordown, rev_pulse, rev_cnt, lim_err
  );
endinterface

// File: rtl/updown_dir_ctrl.sv
// Direction controller for an up/down counter: debounced manual direction,
// or automatic ping-pong between lo_lim and hi_lim with reversal counting.
module updown_dir_ctrl #(
  parameter int DB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  updown_dir_ctrl_if.slave    bus
);
  localparam int DBW = $clog2(DB_CYCLES + 1);
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  typedef enum logic [1:0] {S_MAN, S_UP, S_DN, S_BAD} state_t;

  logic           sync1_q, sync1_d;
  logic           sync2_q, sync2_d;
  logic           db_val_q, db_val_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  state_t         state_q, state_d;
  logic           upordown_q, upordown_d;
  logic [7:0]     rev_cnt_q, rev_cnt_d;
  logic           rev_pulse;

  logic           pp_mode;
  logic           lim_bad;
  logic           at_top;
  logic           at_bot;
  state_t         entry_state;

  // The run counts samples that disagree with the accepted value; any
  // agreeing sample restarts it.
  always_comb begin
    sync1_d  = bus.btn_dir;
    sync2_d  = sync1_q;
    db_val_d = db_val_q;
    db_cnt_d = '0;
    if (sync2_q != db_val_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_val_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    pp_mode = (bus.mode == 2'b01);
    lim_bad = (bus.lo_lim >= bus.hi_lim);
    at_top  = ({1'b0, bus.count} == ({1'b0, bus.hi_lim} - 5'd1));
    at_bot  = ({1'b0, bus.count} == ({1'b0, bus.lo_lim} + 5'd1));
    if (lim_bad) begin
      entry_state = S_BAD;
    end else if (bus.count < bus.hi_lim) begin
      entry_state = S_UP;
    end else begin
      entry_state = S_DN;
    end
  end

  // Direction is committed one edge ahead, so reversing when count is one
  // step short of a limit makes the counter land exactly on that limit.
  always_comb begin
    state_d   = state_q;
    rev_pulse = 1'b0;
    if (!pp_mode) begin
      state_d = S_MAN;
    end else begin
      case (state_q)
        S_MAN, S_BAD: state_d = entry_state;
        S_UP: begin
          if (lim_bad) begin
            state_d = S_BAD;
          end else if (at_top) begin
            state_d   = S_DN;
            rev_pulse = 1'b1;
          end else if (bus.count > bus.hi_lim) begin
            state_d = S_DN;
          end
        end
        S_DN: begin
          if (lim_bad) begin
            state_d = S_BAD;
          end else if (at_bot) begin
            state_d   = S_UP;
            rev_pulse = 1'b1;
          end else if (bus.count < bus.lo_lim) begin
            state_d = S_UP;
          end
        end
        default: state_d = S_MAN;
      endcase
    end

    case (state_d)
      S_UP:    upordown_d = 1'b1;
      S_DN:    upordown_d = 1'b0;
      S_MAN:   upordown_d = db_val_q;
      default: upordown_d = upordown_q;
    endcase

    rev_cnt_d = rev_cnt_q;
    if (rev_pulse && (rev_cnt_q != 8'hFF)) begin
      rev_cnt_d = rev_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_val_q   <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= S_MAN;
      upordown_q <= 1'b1;
      rev_cnt_q  <= 8'd0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      db_val_q   <= db_val_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      upordown_q <= upordown_d;
      rev_cnt_q  <= rev_cnt_d;
    end
  end

  assign bus.upordown  = upordown_q;
  assign bus.rev_pulse = rev_pulse;
  assign bus.rev_cnt   = rev_cnt_q;
  assign bus.lim_err   = (state_q == S_BAD) && pp_mode;
endmodule

// File: tb/tb_updown_dir_ctrl.sv
// Bench for updown_dir_ctrl: a 4-bit up/down counter closes the loop, a
// behavioural model is compared every cycle, plus hand-computed spot checks.
module tb_updown_dir_ctrl;
  localparam int DB = 4;

  logic clk;
  logic reset;
  updown_dir_ctrl_if bus();

  updown_dir_ctrl #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream counter: steps every edge in the direction the DUT requests.
  logic [3:0] cnt_q;
  logic       cnt_en;
  logic       cnt_ld;
  logic [3:0] cnt_ld_val;
  always @(posedge clk) begin
    if (cnt_ld)      cnt_q <= cnt_ld_val;
    else if (cnt_en) cnt_q <= bus.upordown ? cnt_q + 4'd1 : cnt_q - 4'd1;
  end
  assign bus.count = cnt_q;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: "heading" up/down inside a ping-pong run, or manual.
  typedef struct packed {
    logic       pp;
    logic       bad;
    logic       up;
    logic       dir;
    logic       db;
    logic [7:0] run;
    logic       h1;
    logic       h2;
    logic [7:0] rev;
  } model_t;

  model_t m;

  function automatic logic model_rev(model_t s, logic [1:0] md, int c, int lo, int hi);
    if (md != 2'b01 || !s.pp || s.bad || lo >= hi) return 1'b0;
    return s.up ? (c + 1 == hi) : (c == lo + 1);
  endfunction

  function automatic model_t model_step(model_t s, logic [1:0] md, logic btn,
                                        int c, int lo, int hi);
    model_t n;
    logic rev;
    n   = s;
    rev = model_rev(s, md, c, lo, hi);
    if (s.h2 != s.db) begin
      n.run = s.run + 8'd1;
      if (int'(n.run) == DB) begin
        n.db  = s.h2;
        n.run = 8'd0;
      end
    end else begin
      n.run = 8'd0;
    end
    n.h2 = s.h1;
    n.h1 = btn;
    if (md != 2'b01) begin
      n.pp  = 1'b0;
      n.bad = 1'b0;
      n.dir = s.db;
    end else if (!s.pp || s.bad) begin
      n.pp = 1'b1;
      if (lo >= hi) begin
        n.bad = 1'b1;
      end else begin
        n.bad = 1'b0;
        n.up  = (c < hi);
        n.dir = n.up;
      end
    end else if (lo >= hi) begin
      n.bad = 1'b1;
    end else begin
      if (s.up && (c == hi - 1 || c > hi))       n.up = 1'b0;
      else if (!s.up && (c == lo + 1 || c < lo)) n.up = 1'b1;
      n.dir = n.up;
    end
    if (rev && s.rev != 8'hFF) n.rev = s.rev + 8'd1;
    return n;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m <= '{pp: 1'b0, bad: 1'b0, up: 1'b1, dir: 1'b1, db: 1'b0,
             run: 8'd0, h1: 1'b0, h2: 1'b0, rev: 8'd0};
    end else begin
      m <= model_step(m, bus.mode, bus.btn_dir, int'(bus.count),
                      int'(bus.lo_lim), int'(bus.hi_lim));
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("model_upordown", int'(bus.upordown), int'(m.dir));
      chk("model_rev_pulse", int'(bus.rev_pulse),
          int'(model_rev(m, bus.mode, int'(bus.count), int'(bus.lo_lim), int'(bus.hi_lim))));
      chk("model_rev_cnt", int'(bus.rev_cnt), int'(m.rev));
      chk("model_lim_err", int'(bus.lim_err), int'(m.bad && bus.mode == 2'b01));
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.mode = 2'b00;
    bus.btn_dir = 1'b0;
    bus.lo_lim = 4'd2;
    bus.hi_lim = 4'd9;
    cnt_en = 1'b0;
    cnt_ld = 1'b1;
    cnt_ld_val = 4'd0;
    step(2);
    $display("phase: reset state");
    chk("rst_upordown", int'(bus.upordown), 1);
    chk("rst_rev_pulse", int'(bus.rev_pulse), 0);
    chk("rst_rev_cnt", int'(bus.rev_cnt), 0);
    chk("rst_lim_err", int'(bus.lim_err), 0);

    $display("phase: sweep lo=2 hi=9 from 0");
    cnt_ld = 1'b0;
    bus.mode = 2'b01;
    reset = 1'b0;
    cnt_en = 1'b1;
    step(8);
    chk("sweep_cnt8", int'(bus.count), 8);
    chk("sweep_rev_at8", int'(bus.rev_pulse), 1);
    step(1);
    chk("sweep_peak", int'(bus.count), 9);
    chk("sweep_dir_dn", int'(bus.upordown), 0);
    chk("sweep_revcnt1", int'(bus.rev_cnt), 1);
    step(6);
    chk("sweep_cnt3", int'(bus.count), 3);
    chk("sweep_rev_at3", int'(bus.rev_pulse), 1);
    step(1);
    chk("sweep_bottom", int'(bus.count), 2);
    chk("sweep_revcnt2", int'(bus.rev_cnt), 2);
    chk("sweep_dir_up", int'(bus.upordown), 1);
    step(7);
    chk("sweep_peak2", int'(bus.count), 9);

    $display("phase: async reset mid-sweep");
    #1 reset = 1'b1;
    #1;
    chk("arst_upordown", int'(bus.upordown), 1);
    chk("arst_rev_pulse", int'(bus.rev_pulse), 0);
    chk("arst_rev_cnt", int'(bus.rev_cnt), 0);
    chk("arst_lim_err", int'(bus.lim_err), 0);
    step(1);
    reset = 1'b0;
    step(12);

    $display("phase: debounce");
    bus.mode = 2'b00;
    bus.btn_dir = 1'b0;
    step(4);
    chk("db_low", int'(bus.upordown), 0);
    for (int i = 0; i < 10; i++) begin
      bus.btn_dir = ~bus.btn_dir;
      step(2);
      chk("db_toggle_hold", int'(bus.upordown), 0);
    end
    bus.btn_dir = 1'b0;
    step(4);
    bus.btn_dir = 1'b1;
    step(6);
    chk("db_not_yet", int'(bus.upordown), 0);
    step(1);
    chk("db_accept7", int'(bus.upordown), 1);

    $display("phase: invalid limits lo=9 hi=3");
    bus.lo_lim = 4'd9;
    bus.hi_lim = 4'd3;
    bus.mode = 2'b01;
    step(1);
    chk("bad_lim_err", int'(bus.lim_err), 1);
    chk("bad_frozen", int'(bus.upordown), 1);
    step(3);
    chk("bad_frozen2", int'(bus.upordown), 1);
    chk("bad_no_rev", int'(bus.rev_pulse), 0);
    bus.hi_lim = 4'd12;
    step(1);
    chk("bad_cleared", int'(bus.lim_err), 0);
    step(20);

    $display("phase: out-of-range entry lo=4 hi=8 count=13");
    bus.mode = 2'b00;
    cnt_en = 1'b0;
    cnt_ld = 1'b1;
    cnt_ld_val = 4'd13;
    bus.lo_lim = 4'd4;
    bus.hi_lim = 4'd8;
    step(1);
    cnt_ld = 1'b0;
    bus.mode = 2'b01;
    step(1);
    chk("oor_dir_dn", int'(bus.upordown), 0);
    cnt_en = 1'b1;
    for (int j = 1; j <= 7; j++) begin
      step(1);
      chk("oor_no_rev", int'(bus.rev_pulse), 0);
    end
    step(1);
    chk("oor_cnt5", int'(bus.count), 5);
    chk("oor_rev_at5", int'(bus.rev_pulse), 1);
    step(1);
    chk("oor_bottom", int'(bus.count), 4);
    chk("oor_dir_up", int'(bus.upordown), 1);

    $display("phase: tight limits lo=5 hi=6");
    reset = 1'b1;
    bus.mode = 2'b00;
    cnt_en = 1'b0;
    cnt_ld = 1'b1;
    cnt_ld_val = 4'd5;
    bus.lo_lim = 4'd5;
    bus.hi_lim = 4'd6;
    step(1);
    reset = 1'b0;
    cnt_ld = 1'b0;
    bus.mode = 2'b01;
    step(1);
    cnt_en = 1'b1;
    chk("tight_dir_up", int'(bus.upordown), 1);
    chk("tight_rev0", int'(bus.rev_pulse), 1);
    step(1);
    chk("tight_cnt6", int'(bus.count), 6);
    chk("tight_rev1", int'(bus.rev_pulse), 1);
    step(9);
    chk("tight_revcnt10", int'(bus.rev_cnt), 10);
    chk("tight_cnt5", int'(bus.count), 5);
    step(260);
    chk("tight_sat", int'(bus.rev_cnt), 255);
    chk("tight_rev_sat", int'(bus.rev_pulse), 1);

    $display("phase: leave ping-pong, rev_cnt holds");
    bus.mode = 2'b00;
    step(3);
    chk("hold_rev_cnt", int'(bus.rev_cnt), 255);
    chk("hold_no_rev", int'(bus.rev_pulse), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
